// File: rtl/alu_fib_sequencer_pkg.sv
// Shared definitions for the Fibonacci sequencer and the RV32I ALU it drives:
// the ALU control codes and the sequencer state type.
package alu_fib_sequencer_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLTU = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b1001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b1010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b1011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    CHK,
    DONE
  } fib_state_t;

endpackage

// File: rtl/alu_fib_sequencer_if.sv
// Request/result handshakes plus the ALU operand/control bus of the sequencer.
// The slave side is the sequencer; the master side is its parent (or a bench).
interface alu_fib_sequencer_if
  import alu_fib_sequencer_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 7
);

  logic                  start_valid;
  logic                  start_ready;
  logic [CW-1:0]         n_in;
  logic                  res_valid;
  logic                  res_ready;
  logic [N-1:0]          res_value;
  logic                  res_overflow;
  logic                  busy;
  logic [N-1:0]          alu_op1;
  logic [N-1:0]          alu_op2;
  logic [ALU_CTRL_W-1:0] alu_ctrl;
  logic [N-1:0]          alu_res;

  modport master (
    output start_valid, n_in, res_ready, alu_res,
    input  start_ready, res_valid, res_value, res_overflow, busy,
           alu_op1, alu_op2, alu_ctrl
  );

  modport slave (
    input  start_valid, n_in, res_ready, alu_res,
    output start_ready, res_valid, res_value, res_overflow, busy,
           alu_op1, alu_op2, alu_ctrl
  );

endinterface

// File: rtl/alu.sv
// Shared combinational RV32I ALU. Instantiated by the datapath top, next to
// the Fibonacci sequencer which borrows it while busy.
module alu
  import alu_fib_sequencer_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0]          operand1,
  input  logic [N-1:0]          operand2,
  input  logic [ALU_CTRL_W-1:0] alucontrol,
  output logic [N-1:0]          alu_result
);

  localparam int SW = $clog2(N);

  logic [SW-1:0] shamt;

  assign shamt = operand2[SW-1:0];

  // Select the operation; unknown control codes produce zero.
  always_comb begin
    alu_result = '0;
    case (alucontrol)
      ALU_ADD:  alu_result = operand1 + operand2;
      ALU_SUB:  alu_result = operand1 - operand2;
      ALU_AND:  alu_result = operand1 & operand2;
      ALU_OR:   alu_result = operand1 | operand2;
      ALU_XOR:  alu_result = operand1 ^ operand2;
      ALU_SLL:  alu_result = operand1 << shamt;
      ALU_SRL:  alu_result = operand1 >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(operand1) >>> shamt);
      ALU_SLT:  alu_result = {{(N-1){1'b0}}, $signed(operand1) < $signed(operand2)};
      ALU_SLTU: alu_result = {{(N-1){1'b0}}, operand1 < operand2};
      default:  alu_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_fib_sequencer.sv
// Iterative Fibonacci controller. Computes F(n) mod 2^N by alternating an
// ALU_ADD (next term) with an ALU_SLTU (wrap test: sum < addend means the
// add carried out) on the shared ALU, and reports a sticky overflow flag.
module alu_fib_sequencer
  import alu_fib_sequencer_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 7
) (
  input logic               clk,
  input logic               rst,
  alu_fib_sequencer_if.slave bus
);

  fib_state_t    state, state_n;
  logic [N-1:0]  a, a_n;
  logic [N-1:0]  b, b_n;
  logic [N-1:0]  t, t_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ovf, ovf_n;

  // State and datapath registers; reset drops any computation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      t     <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      a     <= a_n;
      b     <= b_n;
      t     <= t_n;
      cnt   <= cnt_n;
      ovf   <= ovf_n;
    end
  end

  // Next-state/datapath update and output decode; outputs depend only on
  // registered state, so handshake inputs never reach an output directly.
  always_comb begin
    state_n          = state;
    a_n              = a;
    b_n              = b;
    t_n              = t;
    cnt_n            = cnt;
    ovf_n            = ovf;
    bus.start_ready  = 1'b0;
    bus.res_valid    = 1'b0;
    bus.res_value    = '0;
    bus.res_overflow = 1'b0;
    bus.busy         = 1'b0;
    bus.alu_op1      = '0;
    bus.alu_op2      = '0;
    bus.alu_ctrl     = ALU_ADD;

    case (state)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) begin
          a_n   = '0;
          ovf_n = 1'b0;
          if (bus.n_in == '0) begin
            b_n     = '0;
            state_n = DONE;
          end else if (bus.n_in == CW'(1)) begin
            b_n     = N'(1);
            state_n = DONE;
          end else begin
            b_n     = N'(1);
            cnt_n   = bus.n_in - CW'(1);
            state_n = ADD;
          end
        end
      end

      ADD: begin
        bus.busy     = 1'b1;
        bus.alu_op1  = a;
        bus.alu_op2  = b;
        bus.alu_ctrl = ALU_ADD;
        t_n          = bus.alu_res;
        state_n      = CHK;
      end

      CHK: begin
        bus.busy     = 1'b1;
        bus.alu_op1  = t;
        bus.alu_op2  = b;
        bus.alu_ctrl = ALU_SLTU;
        if (bus.alu_res[0]) begin
          ovf_n = 1'b1;
        end
        a_n   = b;
        b_n   = t;
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_n = DONE;
        end else begin
          state_n = ADD;
        end
      end

      DONE: begin
        bus.res_valid    = 1'b1;
        bus.res_value    = b;
        bus.res_overflow = ovf;
        if (bus.res_ready) begin
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_fib_sequencer.sv
// Self-checking bench for alu_fib_sequencer driving the shared ALU. Expected
// results come from a plain-arithmetic Fibonacci model with wrap detection.
module tb_alu_fib_sequencer;
  import alu_fib_sequencer_pkg::*;

  localparam int N  = 32;
  localparam int CW = 7;

  logic clk = 1'b0;
  logic rst;

  int vectors     = 0;
  int miscompares = 0;

  alu_fib_sequencer_if #(.N(N), .CW(CW)) bus ();

  alu_fib_sequencer #(.N(N), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  alu #(.N(N)) u_alu (
    .operand1   (bus.alu_op1),
    .operand2   (bus.alu_op2),
    .alucontrol (bus.alu_ctrl),
    .alu_result (bus.alu_res)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // F(n) mod 2^32 and whether any partial sum reached 2^32.
  function automatic void fibModel(input int n, output logic [31:0] value, output bit wrapped);
    longint unsigned fa, fb, s;
    fa = 0;
    fb = 1;
    wrapped = 1'b0;
    if (n == 0) begin
      value = 32'd0;
      return;
    end
    for (int i = 2; i <= n; i++) begin
      s = fa + fb;
      if (s >= 64'h1_0000_0000) wrapped = 1'b1;
      fa = fb;
      fb = s & 64'hFFFF_FFFF;
    end
    value = fb[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_start_ready"}, 64'(bus.start_ready), 64'd1);
    checkOutput({tag, "_res_valid"}, 64'(bus.res_valid), 64'd0);
    checkOutput({tag, "_res_value"}, 64'(bus.res_value), 64'd0);
    checkOutput({tag, "_res_overflow"}, 64'(bus.res_overflow), 64'd0);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
    checkOutput({tag, "_alu_op1"}, 64'(bus.alu_op1), 64'd0);
    checkOutput({tag, "_alu_op2"}, 64'(bus.alu_op2), 64'd0);
    checkOutput({tag, "_alu_ctrl"}, 64'(bus.alu_ctrl), 64'(ALU_ADD));
  endtask

  task automatic waitReady();
    int k;
    k = 0;
    while (!bus.start_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) checkOutput("ready_timeout", 64'(bus.start_ready), 64'd1);
  endtask

  // One request: accept n, follow the ALU traffic, check the result, hold the
  // result for 'holdoff' cycles with res_ready low, then take it.
  task automatic applyStimulus(input int n, input int holdoff, input bit stray);
    logic [31:0] expV;
    bit          expW;
    logic [31:0] ma, mb, sum;
    int          cycles, busyCnt, seqBad, expLat;
    string       tg;

    fibModel(n, expV, expW);
    tg = $sformatf("n%0d", n);
    waitReady();
    bus.start_valid = 1'b1;
    bus.n_in        = CW'(n);
    bus.res_ready   = (holdoff == 0);
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;

    cycles  = 1;
    busyCnt = 0;
    seqBad  = 0;
    ma      = 32'd0;
    mb      = 32'd1;
    while (!bus.res_valid && cycles < 400) begin
      if (bus.busy) begin
        if (busyCnt % 2 == 0) begin
          if (bus.alu_ctrl !== ALU_ADD || bus.alu_op1 !== ma || bus.alu_op2 !== mb) seqBad++;
        end else begin
          sum = ma + mb;
          if (bus.alu_ctrl !== ALU_SLTU || bus.alu_op1 !== sum || bus.alu_op2 !== mb) seqBad++;
          ma = mb;
          mb = sum;
        end
        busyCnt++;
      end
      if (stray) begin
        bus.start_valid = 1'($urandom_range(0, 1));
        bus.n_in        = CW'($urandom);
      end
      @(negedge clk);
      cycles++;
    end
    bus.start_valid = 1'b0;
    if (cycles >= 400) begin
      checkOutput({tg, "_result_timeout"}, 64'(bus.res_valid), 64'd1);
      return;
    end

    // DONE follows the 2(n-1) busy cycles; cycle 1 is the one after acceptance.
    expLat = (n < 2) ? 1 : 2 * (n - 1) + 1;
    checkOutput({tg, "_latency"}, 64'(cycles), 64'(expLat));
    checkOutput({tg, "_busy_cycles"}, 64'(busyCnt), 64'((n < 2) ? 0 : 2 * (n - 1)));
    checkOutput({tg, "_alu_sequence_errors"}, 64'(seqBad), 64'd0);
    checkOutput({tg, "_value"}, 64'(bus.res_value), 64'(expV));
    checkOutput({tg, "_overflow"}, 64'(bus.res_overflow), 64'(expW));
    checkOutput({tg, "_start_ready_in_done"}, 64'(bus.start_ready), 64'd0);

    for (int h = 0; h < holdoff; h++) begin
      bus.start_valid = stray;
      @(negedge clk);
      checkOutput({tg, "_hold_valid"}, 64'(bus.res_valid), 64'd1);
      checkOutput({tg, "_hold_value"}, 64'(bus.res_value), 64'(expV));
      checkOutput({tg, "_hold_overflow"}, 64'(bus.res_overflow), 64'(expW));
    end
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b1;
    @(negedge clk);
    checkOutput({tg, "_cleared_valid"}, 64'(bus.res_valid), 64'd0);
    checkOutput({tg, "_cleared_value"}, 64'(bus.res_value), 64'd0);
    checkOutput({tg, "_cleared_overflow"}, 64'(bus.res_overflow), 64'd0);
    checkOutput({tg, "_back_to_idle"}, 64'(bus.start_ready), 64'd1);
  endtask

  initial begin
    int seen;

    rst             = 1'b1;
    bus.start_valid = 1'b0;
    bus.n_in        = '0;
    bus.res_ready   = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0, 0, 1'b0);
    applyStimulus(1, 0, 1'b0);
    applyStimulus(10, 0, 1'b0);
    applyStimulus(47, 0, 1'b0);
    applyStimulus(48, 0, 1'b0);
    applyStimulus(5, 0, 1'b0);
    applyStimulus(6, 5, 1'b1);
    applyStimulus(9, 2, 1'b1);

    waitReady();
    bus.start_valid = 1'b1;
    bus.n_in        = CW'(20);
    bus.res_ready   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("midrst_in_chk", 64'(bus.alu_ctrl), 64'(ALU_SLTU));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdleOutputs("midrst");
    seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.res_valid) seen++;
    end
    checkOutput("midrst_no_result", 64'(seen), 64'd0);
    applyStimulus(3, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(int'($urandom_range(0, 127)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
